deco_keyboard_buf: RTL and testbench

Parametrised successor to the matrix-keyboard decoder. It detects key presses on the scanned key-code bus, one event per press with no auto-repeat, and buffers them in an internal FIFO. When the send key is pressed it streams the buffered codes to the UART transmitter over a valid/ready handshake. It sits between the keyboard scanner and the UART TX path.

---
 rtl/deco_keyboard_buf.sv | 184 ++++++++++++++++++
 tb/tb_deco_keyboard_buf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deco_keyboard_buf.sv
// ---------------------------------------------------------------------------
// deco_keyboard_buf
//
// Purpose:
//   Detects key presses on the scanned key-code bus (one event per press, no
//   auto-repeat) and buffers them in an internal FIFO. A press of the send
//   key streams the buffered codes to the UART transmitter over a
//   valid/ready handshake.
//
// Optional feature:
//   DECO_KBD_BACKSPACE_EN - when defined, BKSP_CODE removes the newest
//   buffered entry instead of being stored as an ordinary key.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   data       in   key code from the scanner (IDLE_CODE when released)
//   oData      out  FIFO head code under transmission (0 outside SEND)
//   oValid     out  oData is valid (SEND state only)
//   iReady     in   downstream accepts oData this cycle
//   send_data  out  one-cycle pulse on the first cycle of a burst
//   oBusy      out  high while in SEND
//   oCount     out  number of buffered entries (0..DEPTH)
//   oOverflow  out  sticky: a press was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module deco_keyboard_buf #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] IDLE_CODE = 8'h00,
    parameter logic [DATA_W-1:0] SEND_CODE = 8'h46,
    parameter logic [DATA_W-1:0] BKSP_CODE = 8'h42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W-1:0]        oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     send_data,
    output logic                     oBusy,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_SEND    = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [DATA_W-1:0]   d_q, d_p;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic                ovf_q,    ovf_d;
    logic                send_q,   send_d;
    logic                valid_q,  valid_d;
    logic                push_s;
    logic                event_s;
    logic [DATA_W-1:0]   mem [DEPTH];

    // A press is a change to a non-idle code; key-to-key changes count too.
    assign event_s = (d_q != d_p) && (d_q != IDLE_CODE);

    // Input sampling pipeline: d_q is the current code, d_p the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= IDLE_CODE;
            d_p <= IDLE_CODE;
        end else begin
            d_q <= data;
            d_p <= d_q;
        end
    end

    // Next-state, FIFO pointer and flag logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        send_d   = 1'b0;
        push_s   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (event_s) begin
                    if (d_q == SEND_CODE) begin
                        // An empty buffer makes the send key a no-op.
                        if (count_q != {CNT_W{1'b0}}) begin
                            state_d = ST_SEND;
                            send_d  = 1'b1;
                            ovf_d   = 1'b0;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
`ifdef DECO_KBD_BACKSPACE_EN
                    else if (d_q == BKSP_CODE) begin
                        // Undo the newest push; the backspace code itself is never stored.
                        if (count_q != {CNT_W{1'b0}}) begin
                            wr_ptr_d = wr_ptr_q - PTR_W'(1);
                            count_d  = count_q - CNT_W'(1);
                        end else begin
                            count_d  = count_q;
                        end
                    end
`endif
                    else begin
                        if (count_q != FULL_CNT) begin
                            push_s   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            count_d  = count_q + CNT_W'(1);
                        end else begin
                            ovf_d    = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_SEND: begin
                // oValid is always high here, so iReady alone marks a transfer.
                // Key events are ignored for the whole burst.
                if (iReady) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
        valid_d = (state_d == ST_SEND);
    end

    // State, pointer, count and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_COLLECT;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            send_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            send_q   <= send_d;
            valid_q  <= valid_d;
        end
    end

    // FIFO storage; contents need no reset because count/valid gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= d_q;
        end
    end

    // oData is forced to zero outside a burst so it never shows stale storage.
    assign oData     = valid_q ? mem[rd_ptr_q] : {DATA_W{1'b0}};
    assign oValid    = valid_q;
    assign oBusy     = valid_q;
    assign send_data = send_q;
    assign oCount    = count_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_deco_keyboard_buf.sv
// ---------------------------------------------------------------------------
// tb_deco_keyboard_buf
//
// Directed self-checking bench for deco_keyboard_buf, built with DEPTH=4 so
// the full/overflow boundary is reachable with short sequences. Expected
// backspace behaviour follows DECO_KBD_BACKSPACE_EN as seen by this file.
// ---------------------------------------------------------------------------
module tb_deco_keyboard_buf;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [7:0] oData;
    logic       oValid;
    logic       iReady;
    logic       send_data;
    logic       oBusy;
    logic [2:0] oCount;
    logic       oOverflow;

    int checks = 0;
    int errors = 0;

    deco_keyboard_buf #(
        .DATA_W    (8),
        .DEPTH     (4),
        .IDLE_CODE (8'h00),
        .SEND_CODE (8'h46),
        .BKSP_CODE (8'h42)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .oData     (oData),
        .oValid    (oValid),
        .iReady    (iReady),
        .send_data (send_data),
        .oBusy     (oBusy),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One press: code for one edge, then idle; the push lands on the second edge.
    task automatic press(input logic [7:0] code);
        data = code;
        step();
        data = 8'h00;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; data = 8'h00; iReady = 1'b0;
        step(); step();
        checks++;
        if ({oData, oValid, send_data, oBusy, oCount, oOverflow} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %b %b %b %0d %b, want all 0",
                     oData, oValid, send_data, oBusy, oCount, oOverflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        data = 8'h31;
        step();
        checks++;
        if (oCount !== 3'd0) begin
            errors++; $display("FAIL press_edge1: oCount=%0d want 0", oCount);
        end
        step();
        checks++;
        if (oCount !== 3'd1) begin
            errors++; $display("FAIL press_edge2: oCount=%0d want 1", oCount);
        end
        step();
        data = 8'h00;
        step(); step();
        checks++;
        if (oCount !== 3'd1) begin
            errors++; $display("FAIL press_no_repeat: oCount=%0d want 1", oCount);
        end
        // Flush the single entry.
        iReady = 1'b1;
        press(8'h46);
        checks++;
        if (oData !== 8'h31 || oValid !== 1'b1) begin
            errors++; $display("FAIL press_flush: oData=%h oValid=%b want 31 1", oData, oValid);
        end
        step();
        checks++;
        if (oBusy !== 1'b0 || oCount !== 3'd0) begin
            errors++; $display("FAIL press_flush_end: oBusy=%b oCount=%0d want 0 0", oBusy, oCount);
        end
    endtask

    task automatic test_send();
        logic [7:0] exp_codes [3];
        exp_codes[0] = 8'h31; exp_codes[1] = 8'h32; exp_codes[2] = 8'h33;
        iReady = 1'b1;
        press(8'h31); press(8'h32); press(8'h33);
        checks++;
        if (oCount !== 3'd3) begin
            errors++; $display("FAIL send_load: oCount=%0d want 3", oCount);
        end
        press(8'h46);
        checks++;
        if (send_data !== 1'b1 || oValid !== 1'b1 || oBusy !== 1'b1) begin
            errors++; $display("FAIL send_start: send_data=%b oValid=%b oBusy=%b want 1 1 1",
                               send_data, oValid, oBusy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oData !== exp_codes[i] || oValid !== 1'b1) begin
                errors++; $display("FAIL send_beat%0d: oData=%h oValid=%b want %h 1",
                                   i, oData, oValid, exp_codes[i]);
            end
            if (i > 0) begin
                checks++;
                if (send_data !== 1'b0) begin
                    errors++; $display("FAIL send_pulse_len: send_data=%b at beat %0d want 0", send_data, i);
                end
            end
            step();
        end
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0 || oCount !== 3'd0) begin
            errors++; $display("FAIL send_end: oValid=%b oBusy=%b oCount=%0d want 0 0 0",
                               oValid, oBusy, oCount);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_codes [3];
        int idx;
        exp_codes[0] = 8'h31; exp_codes[1] = 8'h32; exp_codes[2] = 8'h33;
        idx = 0;
        iReady = 1'b0;
        press(8'h31); press(8'h32); press(8'h33);
        press(8'h46);
        for (int cyc = 0; cyc < 40 && oBusy; cyc++) begin
            checks++;
            if (idx > 2 || oData !== exp_codes[idx] || oValid !== 1'b1) begin
                errors++; $display("FAIL stall_beat: cyc %0d oData=%h oValid=%b want %h 1",
                                   cyc, oData, oValid, (idx > 2) ? 8'hxx : exp_codes[idx]);
            end
            iReady = cyc[0];
            if (iReady) idx++;
            step();
        end
        iReady = 1'b0;
        checks++;
        if (idx !== 3 || oBusy !== 1'b0 || oCount !== 3'd0) begin
            errors++; $display("FAIL stall_done: transfers=%0d oBusy=%b oCount=%0d want 3 0 0",
                               idx, oBusy, oCount);
        end
    endtask

    task automatic test_overflow();
        press(8'h31); press(8'h32); press(8'h33); press(8'h34); press(8'h35);
        checks++;
        if (oCount !== 3'd4 || oOverflow !== 1'b1) begin
            errors++; $display("FAIL ovf_full: oCount=%0d oOverflow=%b want 4 1", oCount, oOverflow);
        end
        iReady = 1'b1;
        press(8'h46);
        checks++;
        if (oOverflow !== 1'b0 || send_data !== 1'b1) begin
            errors++; $display("FAIL ovf_clear: oOverflow=%b send_data=%b want 0 1", oOverflow, send_data);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oData !== 8'(8'h31 + i) || oValid !== 1'b1) begin
                errors++; $display("FAIL ovf_beat%0d: oData=%h oValid=%b want %h 1",
                                   i, oData, oValid, 8'(8'h31 + i));
            end
            step();
        end
        checks++;
        if (oBusy !== 1'b0 || oCount !== 3'd0) begin
            errors++; $display("FAIL ovf_end: oBusy=%b oCount=%0d want 0 0", oBusy, oCount);
        end
    endtask

    task automatic test_backspace();
        logic [7:0] exp_codes [3];
        int exp_n;
        int n;
        exp_codes[0] = 8'h31; exp_codes[1] = 8'h32; exp_codes[2] = 8'h42;
`ifdef DECO_KBD_BACKSPACE_EN
        exp_n = 1;
`else
        exp_n = 3;
`endif
        n = 0;
        iReady = 1'b1;
        press(8'h31); press(8'h32); press(8'h42);
        checks++;
        if (oCount !== 3'(exp_n)) begin
            errors++; $display("FAIL bksp_count: oCount=%0d want %0d", oCount, exp_n);
        end
        press(8'h46);
        for (int cyc = 0; cyc < 20 && oBusy; cyc++) begin
            if (n < exp_n) begin
                checks++;
                if (oData !== exp_codes[n]) begin
                    errors++; $display("FAIL bksp_beat%0d: oData=%h want %h", n, oData, exp_codes[n]);
                end
            end
            n++;
            step();
        end
        checks++;
        if (n !== exp_n || oBusy !== 1'b0) begin
            errors++; $display("FAIL bksp_beats: beats=%0d oBusy=%b want %0d 0", n, oBusy, exp_n);
        end
    endtask

    task automatic test_empty_send();
        iReady = 1'b1;
        press(8'h46);
        checks++;
        if (send_data !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL empty_send: send_data=%b oValid=%b oBusy=%b want 0 0 0",
                               send_data, oValid, oBusy);
        end
        step();
        checks++;
        if (oValid !== 1'b0 || oCount !== 3'd0) begin
            errors++; $display("FAIL empty_send_later: oValid=%b oCount=%0d want 0 0", oValid, oCount);
        end
    endtask

    task automatic test_reset_mid_send();
        iReady = 1'b1;
        press(8'h31); press(8'h32); press(8'h33);
        press(8'h46);
        step();
        checks++;
        if (oData !== 8'h32 || oValid !== 1'b1) begin
            errors++; $display("FAIL mid_beat2: oData=%h oValid=%b want 32 1", oData, oValid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({oData, oValid, send_data, oBusy, oCount, oOverflow} !== 15'd0) begin
            errors++; $display("FAIL mid_reset: got %h %b %b %b %0d %b, want all 0",
                               oData, oValid, send_data, oBusy, oCount, oOverflow);
        end
        press(8'h46);
        checks++;
        if (oValid !== 1'b0 || send_data !== 1'b0) begin
            errors++; $display("FAIL mid_reset_empty: oValid=%b send_data=%b want 0 0", oValid, send_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_send();
        test_stall();
        test_overflow();
        test_backspace();
        test_empty_send();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
